// File: rtl/obj_pkg.sv
// Shared types and defaults for the sprite object layer.
// Slot layout as held in the shadow and active banks.
package obj_pkg;
  localparam int N_OBJ_MAX     = 8;
  localparam int HALF_W        = 320;
  localparam int HALF_H        = 240;
  localparam int OBJ_W_DEF     = 20;
  localparam int OBJ_H_DEF     = 20;
  localparam int SHEET_W_DEF   = 320;
  localparam int ROM_DEPTH_DEF = 76800;
  localparam int ADDR_W_DEF    = 17;

  typedef struct packed {
    logic                  en;
    logic                  blink;
    logic [8:0]            x;
    logic [8:0]            y;
    logic [ADDR_W_DEF-1:0] base;
  } obj_slot_t;
endpackage

// File: rtl/obj_layer_engine_hit.sv
// Per-slot bounds test and texel offset for one object.
// Bounds use 10 bits so objects at the right/bottom edge clip.
module obj_hit_unit
  import obj_pkg::*;
#(
  parameter int OBJ_W = OBJ_W_DEF,
  parameter int OBJ_H = OBJ_H_DEF
) (
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic       en,
  input  logic       blink,
  input  logic [8:0] ox,
  input  logic [8:0] oy,
  input  logic       blink_phase,
  output logic       hit,
  output logic [8:0] dx,
  output logic [8:0] dy
);
  logic [9:0] x_end;
  logic [9:0] y_end;
  logic       in_x;
  logic       in_y;

  assign x_end = {1'b0, ox} + 10'(OBJ_W);
  assign y_end = {1'b0, oy} + 10'(OBJ_H);
  assign in_x  = (x >= ox) && ({1'b0, x} < x_end);
  assign in_y  = (y >= oy) && ({1'b0, y} < y_end);
  assign hit   = en && !(blink && blink_phase) && in_x && in_y;
  assign dx    = x - ox;
  assign dy    = y - oy;
endmodule

// File: rtl/obj_layer_engine.sv
// Multi-object sprite layer: half-res hit test, priority select,
// sheet address generation; 2-cycle latency, frame-synced commit.
module obj_layer_engine
  import obj_pkg::*;
#(
  parameter int N_OBJ        = 4,
  parameter int OBJ_W        = OBJ_W_DEF,
  parameter int OBJ_H        = OBJ_H_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int SHEET_W      = SHEET_W_DEF,
  parameter int ROM_DEPTH    = ROM_DEPTH_DEF,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_start,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic              cfg_en,
  input  logic              cfg_blink,
  input  logic [8:0]        cfg_x,
  input  logic [8:0]        cfg_y,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              isObject,
  output logic [2:0]        obj_id
);
  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  localparam int SW  = ADDR_W + 1;

  obj_slot_t shadow    [N_OBJ];
  obj_slot_t shadow_nx [N_OBJ];
  obj_slot_t active    [N_OBJ];
  obj_slot_t new_slot;

  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;

  logic [8:0]       x;
  logic [8:0]       y;
  logic [N_OBJ-1:0] hit;
  logic [8:0]       dx [N_OBJ];
  logic [8:0]       dy [N_OBJ];

  logic [N_OBJ-1:0]  s1_hit;
  logic [8:0]        s1_dx   [N_OBJ];
  logic [8:0]        s1_dy   [N_OBJ];
  logic [ADDR_W-1:0] s1_base [N_OBJ];

  logic              sel_hit;
  logic [2:0]        sel_id;
  logic [8:0]        sel_dx;
  logic [8:0]        sel_dy;
  logic [ADDR_W-1:0] sel_base;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     wrapped;

  assign new_slot = '{
    en:    cfg_en,
    blink: cfg_blink,
    x:     cfg_x,
    y:     cfg_y,
    base:  ADDR_W_DEF'(cfg_base)
  };

  // Same-cycle write is folded in so a commit on that edge includes it.
  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      shadow_nx[i] = shadow[i];
      if (cfg_we && cfg_idx == 3'(i))
        shadow_nx[i] = new_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      for (int i = 0; i < N_OBJ; i++)
        shadow[i] <= shadow_nx[i];
      if (frame_start) begin
        for (int i = 0; i < N_OBJ; i++)
          active[i] <= shadow_nx[i];
        if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign x = h_cnt[9:1];
  assign y = v_cnt[9:1];

  for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
    obj_hit_unit #(
      .OBJ_W(OBJ_W),
      .OBJ_H(OBJ_H)
    ) u_hit (
      .x          (x),
      .y          (y),
      .en         (active[g].en),
      .blink      (active[g].blink),
      .ox         (active[g].x),
      .oy         (active[g].y),
      .blink_phase(blink_phase),
      .hit        (hit[g]),
      .dx         (dx[g]),
      .dy         (dy[g])
    );
  end

  // Base is captured with the hit so a commit cannot split a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        s1_dx[i]   <= '0;
        s1_dy[i]   <= '0;
        s1_base[i] <= '0;
      end
    end else begin
      s1_hit <= hit;
      for (int i = 0; i < N_OBJ; i++) begin
        s1_dx[i]   <= dx[i];
        s1_dy[i]   <= dy[i];
        s1_base[i] <= ADDR_W'(active[i].base);
      end
    end
  end

  always_comb begin
    sel_hit  = 1'b0;
    sel_id   = '0;
    sel_dx   = '0;
    sel_dy   = '0;
    sel_base = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        sel_hit  = 1'b1;
        sel_id   = 3'(i);
        sel_dx   = s1_dx[i];
        sel_dy   = s1_dy[i];
        sel_base = s1_base[i];
      end
    end
  end

  assign sum = SW'(sel_base) + SW'(sel_dx)
             + SW'(32'(sel_dy) * SHEET_W);
  assign wrapped = (sum >= SW'(ROM_DEPTH))
                 ? sum - SW'(ROM_DEPTH) : sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      isObject   <= 1'b0;
      obj_id     <= '0;
      pixel_addr <= '0;
    end else begin
      isObject   <= sel_hit;
      obj_id     <= sel_id;
      pixel_addr <= sel_hit ? ADDR_W'(wrapped) : '0;
    end
  end
endmodule

// File: tb/tb_obj_layer_engine.sv
// Directed bench for obj_layer_engine with a latency-tagged
// scoreboard of expected pixel outputs.
`timescale 1ns/1ps
module tb_obj_layer_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_start;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_en;
  logic        cfg_blink;
  logic [8:0]  cfg_x;
  logic [8:0]  cfg_y;
  logic [16:0] cfg_base;
  logic [16:0] pixel_addr;
  logic        isObject;
  logic [2:0]  obj_id;

  obj_layer_engine #(
    .N_OBJ(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .frame_start(frame_start),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_en(cfg_en),
    .cfg_blink(cfg_blink),
    .cfg_x(cfg_x),
    .cfg_y(cfg_y),
    .cfg_base(cfg_base),
    .pixel_addr(pixel_addr),
    .isObject(isObject),
    .obj_id(obj_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          step;
    logic        hit;
    logic [2:0]  id;
    logic [16:0] addr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_step = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input int step,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s #%0d: observed %0d expected %0d",
             tag, step, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("isObject", e.step, 32'(isObject), 32'(e.hit));
      chk("obj_id", e.step, 32'(obj_id), 32'(e.id));
      chk("pixel_addr", e.step, 32'(pixel_addr), 32'(e.addr));
    end
  end

  task automatic pix(input int x, input int y, input logic eh,
                     input logic [2:0] eid, input logic [16:0] ea);
    exp_t e;
    @(negedge clk);
    h_cnt = 10'(x * 2 + ((x % 3 == 0) ? 1 : 0));
    v_cnt = 10'(y * 2 + (y & 1));
    e.due  = cyc + 2;
    e.step = n_step;
    e.hit  = eh;
    e.id   = eid;
    e.addr = ea;
    q.push_back(e);
    n_step++;
  endtask

  task automatic cfg(input int idx, input logic en, input logic bl,
                     input int x, input int y, input int base,
                     input logic fs);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_idx     = 3'(idx);
    cfg_en      = en;
    cfg_blink   = bl;
    cfg_x       = 9'(x);
    cfg_y       = 9'(y);
    cfg_base    = 17'(base);
    frame_start = fs;
    @(negedge clk);
    cfg_we      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++)
      @(posedge clk);
    @(negedge clk);
    chk("drain", 0, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vis [6];
    vis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    h_cnt = '0;
    v_cnt = '0;
    frame_start = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_en = 1'b0;
    cfg_blink = 1'b0;
    cfg_x = '0;
    cfg_y = '0;
    cfg_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_isObject", 0, 32'(isObject), 32'd0);
    chk("rst_addr", 0, 32'(pixel_addr), 32'd0);
    chk("rst_id", 0, 32'(obj_id), 32'd0);
    rst = 1'b0;

    pix(65, 35, 0, 0, 0);

    cfg(0, 1, 0, 65, 35, 14400, 0);
    pix(70, 40, 0, 0, 0);
    fs();
    pix(70, 40, 1, 0, 16005);
    pix(84, 40, 1, 0, 16019);
    pix(85, 40, 0, 0, 0);
    pix(70, 54, 1, 0, 20485);
    pix(70, 55, 0, 0, 0);
    pix(64, 40, 0, 0, 0);

    cfg(1, 1, 0, 65, 35, 1000, 0);
    cfg(0, 1, 0, 70, 40, 14400, 0);
    cfg(5, 1, 0, 0, 0, 7, 0);
    cfg(3, 1, 0, 200, 100, 500, 1);
    pix(72, 42, 1, 0, 15042);
    pix(66, 36, 1, 1, 1321);
    pix(1, 1, 0, 0, 0);
    pix(201, 101, 1, 3, 821);

    cfg(0, 1, 0, 310, 230, 76700, 1);
    pix(315, 235, 1, 0, 1505);
    pix(319, 239, 1, 0, 2789);
    pix(0, 235, 0, 0, 0);
    pix(9, 235, 0, 0, 0);
    pix(320, 235, 1, 0, 1510);
    pix(315, 235, 1, 0, 1505);
    drain();

    chk("pre_rst_hit", 0, 32'(isObject), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_isObject", 0, 32'(isObject), 32'd0);
    chk("mid_rst_addr", 0, 32'(pixel_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pix(315, 235, 0, 0, 0);
    fs();
    pix(315, 235, 0, 0, 0);
    cfg(0, 1, 0, 310, 230, 76700, 1);
    pix(315, 235, 1, 0, 1505);
    drain();

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg(2, 1, 1, 100, 100, 2000, 0);
    cfg(1, 1, 0, 150, 100, 3000, 0);
    pix(105, 105, 0, 0, 0);
    pix(151, 101, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      fs();
      pix(105, 105, vis[k], vis[k] ? 3'd2 : 3'd0,
          vis[k] ? 17'd3605 : 17'd0);
      pix(151, 101, 1, 1, 3321);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/obj_layer_engine.md
Name: obj_layer_engine

Overview:
- Parametrised multi-object sprite layer for the VGA path.
- Takes the raw 640x480 h_cnt/v_cnt, halves them to 320x240, and tests each pixel against N_OBJ runtime-configurable object slots.
- Outputs the sprite-sheet ROM address, a hit flag and the winning object index to the pixel mux, with fixed latency.
- Replaces hard-coded per-stage object placement: the stage controller now writes slots. Adds tear-free frame-synchronous commit and per-object blinking.

Parameters:
- N_OBJ, 4, number of object slots (1..8).
- OBJ_W, 20, object width in half-res pixels.
- OBJ_H, 20, object height in half-res pixels.
- ADDR_W, 17, ROM address width.
- SHEET_W, 320, sprite-sheet row pitch in pixels.
- ROM_DEPTH, 76800, ROM words; addresses wrap modulo this.
- BLINK_FRAMES, 30, frames per blink half-period.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- h_cnt  in  10  VGA horizontal counter (0..639)
- v_cnt  in  10  VGA vertical counter (0..479)
- frame_start  in  1  one-cycle pulse at start of vertical blank
- cfg_we  in  1  slot write strobe
- cfg_idx  in  3  slot index; values >= N_OBJ are ignored
- cfg_en  in  1  slot enable
- cfg_blink  in  1  slot blinks when set
- cfg_x  in  9  object left edge, half-res
- cfg_y  in  9  object top edge, half-res
- cfg_base  in  ADDR_W  sheet address of the object's top-left texel
- pixel_addr  out  ADDR_W  ROM address for the current pixel
- isObject  out  1  current pixel belongs to an enabled, visible object
- obj_id  out  3  index of the winning slot

Behaviour:
- Reset: all shadow and active slots cleared (en=0, blink=0, x=y=0, base=0). frame and blink counters = 0. pixel_addr=0, isObject=0, obj_id=0, effective the cycle after rst is sampled high. Reset mid-frame blanks the output from the next cycle on.
- Config: cfg_we writes the shadow slot only. On frame_start, all shadow slots are copied to active slots. cfg_we and frame_start in the same cycle: the new write is included in the commit. Only active slots affect output, so there is no mid-frame tearing.
- Coordinates: x = h_cnt>>1, y = v_cnt>>1 (9 bits).
- Hit test for slot i: en_i && !(blink_i && blink_phase) && x >= x_i && x < x_i+OBJ_W && y >= y_i && y < y_i+OBJ_H. Compute the bounds in 10 bits so objects near the 319/239 edge clip rather than wrap.
- Priority: lowest hit index wins. Overlapping objects show the lower index.
- Address: base_i + (x-x_i) + (y-y_i)*SHEET_W, computed at ADDR_W+1 bits. If the result is >= ROM_DEPTH, subtract ROM_DEPTH once.
- No hit: isObject=0, pixel_addr=0, obj_id=0. Never hold the previous value.
- Pipeline:
  - Stage 1 registers x, y, the per-slot hit vector and the offsets.
  - Stage 2 registers the priority select and address.
  - Latency is exactly 2 clk from h_cnt/v_cnt to outputs, at throughput 1 pixel/clk.
- Blink: frame_cnt increments on each frame_start. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. The phase change is applied together with the commit on the same frame_start.
- Out-of-range counters (h_cnt>=640 or v_cnt>=480) are treated like any pixel. Downstream masks them with the VGA valid signal.

Decomposition:
- Shared package obj_pkg: N_OBJ_MAX=8, the half-res dimensions 320/240, default OBJ_W/OBJ_H, SHEET_W, ROM_DEPTH, and a struct obj_slot_t {en, blink, x, y, base}.
- One natural sub-module, obj_hit_unit: per-slot combinational bounds compare plus offset, instantiated N_OBJ times via generate. The priority encoder and address adder stay in the top.

Test Plan:
- Reset, then drive h_cnt=130, v_cnt=70 (x=65, y=35) with no config -> isObject=0, pixel_addr=0 after 2 clk.
- Write slot0 {en=1, x=65, y=35, base=14400}, pulse frame_start, drive x=70, y=40 -> isObject=1, obj_id=0, pixel_addr=14400+5+5*320=16005, exactly 2 clk later. Before frame_start the same pixel -> isObject=0.
- Write slot1 at x=65, y=35 and slot0 at x=70, y=40, commit, drive x=72, y=42 -> obj_id=0 (priority). At x=66, y=36 -> obj_id=1.
- Slot0 at x=310, y=230 with base=76700, commit, drive x=315, y=235 -> hit, address (76700+5+1600) mod 76800 = 1505. At x=319, y=239 -> hit. Slot bounds do not wrap to x=0.
- Slot0 with blink=1, BLINK_FRAMES=2, fixed pixel inside the object -> visible for frames 0-1, hidden for frames 2-3, visible for frames 4-5.
- Assert rst during an active hit -> isObject=0 and pixel_addr=0 from the next cycle. After rst, the pixel stays dark until the slot is rewritten and committed.
